// File: rtl/mcp_tx_arbiter.sv
// Round-robin sequencer sharing one MCP sender among NREQ requesters: grant -> asend pulse -> hold -> wait for aready.
// Grant lands one cycle after req is sampled with aready high; aready low holds off all grants; sticky watchdog err.
module mcp_tx_arbiter #(
  parameter int NREQ    = 4,
  parameter int DW      = 8,
  parameter int TIMEOUT = 255
) (
  input  logic                      aclk,
  input  logic                      arst_n,
  input  logic [NREQ-1:0]           req,
  input  logic [NREQ*DW-1:0]        req_data,
  output logic [NREQ-1:0]           gnt,
  output logic [$clog2(NREQ)-1:0]   src_id,
  output logic [DW-1:0]             adatain,
  output logic                      asend,
  input  logic                      aready,
  output logic                      busy,
  output logic                      err
);

  localparam int IDW = $clog2(NREQ);
  localparam int CW  = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

  typedef enum logic [1:0] {S_IDLE, S_SEND, S_HOLD, S_WAIT} state_t;

  state_t            r_state, w_state_nxt;
  logic [IDW-1:0]    r_ptr, w_ptr_nxt;
  logic [IDW-1:0]    r_src, w_src_nxt;
  logic [DW-1:0]     r_dat, w_dat_nxt;
  logic [NREQ-1:0]   r_gnt, w_gnt_nxt;
  logic              r_asend, w_asend_nxt;
  logic              r_busy, w_busy_nxt;
  logic              r_err, w_err_nxt;
  logic [CW-1:0]     r_cnt, w_cnt_nxt;

  logic              w_found;
  logic [IDW-1:0]    w_win;
  logic [DW-1:0]     w_word;

  // Scan starts one past the last winner, so the last winner has lowest priority.
  always_comb begin
    w_found = 1'b0;
    w_win   = '0;
    w_word  = '0;
    for (int k = 1; k <= NREQ; k++) begin
      if (!w_found && req[(int'(r_ptr) + k) % NREQ]) begin
        w_found = 1'b1;
        w_win   = IDW'((int'(r_ptr) + k) % NREQ);
        w_word  = req_data[((int'(r_ptr) + k) % NREQ) * DW +: DW];
      end
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_ptr_nxt   = r_ptr;
    w_src_nxt   = r_src;
    w_dat_nxt   = r_dat;
    w_gnt_nxt   = '0;
    w_asend_nxt = 1'b0;
    w_busy_nxt  = r_busy;
    w_err_nxt   = r_err;
    w_cnt_nxt   = r_cnt;
    case (r_state)
      S_IDLE: begin
        if (w_found && aready) begin
          w_state_nxt        = S_SEND;
          w_ptr_nxt          = w_win;
          w_src_nxt          = w_win;
          w_dat_nxt          = w_word;
          w_gnt_nxt[w_win]   = 1'b1;
          w_asend_nxt        = 1'b1;
          w_busy_nxt         = 1'b1;
        end
      end
      S_SEND: w_state_nxt = S_HOLD;
      // Sender needs a cycle to drop aready after the load pulse.
      S_HOLD: begin
        w_state_nxt = S_WAIT;
        w_cnt_nxt   = '0;
      end
      S_WAIT: begin
        if (aready) begin
          w_state_nxt = S_IDLE;
          w_busy_nxt  = 1'b0;
        end else if (r_cnt != CW'(TIMEOUT)) begin
          w_cnt_nxt = r_cnt + 1'b1;
          if (w_cnt_nxt == CW'(TIMEOUT)) w_err_nxt = 1'b1;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge aclk or negedge arst_n) begin
    if (!arst_n) begin
      r_state <= S_IDLE;
      r_ptr   <= IDW'(NREQ - 1);
      r_src   <= '0;
      r_dat   <= '0;
      r_gnt   <= '0;
      r_asend <= 1'b0;
      r_busy  <= 1'b0;
      r_err   <= 1'b0;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_ptr   <= w_ptr_nxt;
      r_src   <= w_src_nxt;
      r_dat   <= w_dat_nxt;
      r_gnt   <= w_gnt_nxt;
      r_asend <= w_asend_nxt;
      r_busy  <= w_busy_nxt;
      r_err   <= w_err_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  assign gnt     = r_gnt;
  assign src_id  = r_src;
  assign adatain = r_dat;
  assign asend   = r_asend;
  assign busy    = r_busy;
  assign err     = r_err;

endmodule

// File: tb/tb_mcp_tx_arbiter.sv
// Randomized and directed bench for mcp_tx_arbiter against a transaction-level round-robin model.
module tb_mcp_tx_arbiter;
  localparam int NREQ = 4;
  localparam int DW   = 8;
  localparam int TO   = 8;
  localparam int IW   = $clog2(NREQ);

  logic                  aclk = 1'b0;
  logic                  arst_n = 1'b1;
  logic [NREQ-1:0]       req = '0;
  logic [NREQ*DW-1:0]    req_data = '0;
  logic                  aready = 1'b0;
  logic [NREQ-1:0]       gnt;
  logic [IW-1:0]         src_id;
  logic [DW-1:0]         adatain;
  logic                  asend;
  logic                  busy;
  logic                  err;

  int total = 0;
  int bad   = 0;
  int m_ptr;
  int glog[$];
  logic [DW-1:0] m_word [NREQ];

  mcp_tx_arbiter #(.NREQ(NREQ), .DW(DW), .TIMEOUT(TO)) dut (
    .aclk(aclk), .arst_n(arst_n), .req(req), .req_data(req_data),
    .gnt(gnt), .src_id(src_id), .adatain(adatain), .asend(asend),
    .aready(aready), .busy(busy), .err(err)
  );

  always #5 aclk = ~aclk;

  initial begin
    #100000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

  // Reference rule: first requester set, scanning upward from one past the last winner.
  function automatic int pick(input logic [NREQ-1:0] m, input int p);
    for (int k = 1; k <= NREQ; k++)
      if (m[(p + k) % NREQ]) return (p + k) % NREQ;
    return -1;
  endfunction

  task automatic load_words(input logic rnd);
    for (int i = 0; i < NREQ; i++) begin
      if (rnd) m_word[i] = DW'($urandom);
      req_data[i*DW +: DW] = m_word[i];
    end
  endtask

  task automatic do_reset();
    @(negedge aclk);
    arst_n = 1'b0;
    req    = '0;
    aready = 1'b0;
    repeat (2) @(negedge aclk);
    arst_n = 1'b1;
    m_ptr  = NREQ - 1;
    glog.delete();
  endtask

  task automatic do_xfer(input logic [NREQ-1:0] mask, input int dly, input logic newdata);
    int e;
    int n;
    logic ok;
    load_words(newdata);
    req    = mask;
    aready = 1'b1;
    e      = pick(mask, m_ptr);
    n = 0;
    do begin @(negedge aclk); n++; end while (asend !== 1'b1 && n < 6);
    total++;
    if (asend !== 1'b1) begin
      bad++;
      $display("FAIL xfer_grant_timeout: asend=%b required 1 (mask=%b)", asend, mask);
      return;
    end
    total++;
    if ({gnt, src_id, adatain, busy} !== {NREQ'(1 << e), IW'(e), m_word[e], 1'b1}) begin
      bad++;
      $display("FAIL xfer_grant: gnt=%b src=%0d dat=%h busy=%b required gnt=%b src=%0d dat=%h busy=1",
               gnt, src_id, adatain, busy, NREQ'(1 << e), e, m_word[e]);
    end
    m_ptr = e;
    glog.push_back(int'(src_id));
    aready = 1'b0;
    ok = 1'b1;
    repeat (dly + 1) begin
      @(negedge aclk);
      if (asend !== 1'b0 || gnt !== '0 || busy !== 1'b1 || adatain !== m_word[e]) ok = 1'b0;
    end
    total++;
    if (!ok) begin
      bad++;
      $display("FAIL xfer_hold: asend=%b gnt=%b busy=%b dat=%h required 0/0/1/%h",
               asend, gnt, busy, adatain, m_word[e]);
    end
    aready = 1'b1;
    n = 0;
    do begin @(negedge aclk); n++; end while (busy !== 1'b0 && n < 5);
    total++;
    if (busy !== 1'b0) begin
      bad++;
      $display("FAIL ready_return: busy=%b required 0", busy);
    end
  endtask

  task automatic check_order(input string name, input int exp_q[$]);
    logic ok;
    ok = (glog.size() == exp_q.size());
    for (int i = 0; ok && i < exp_q.size(); i++) if (glog[i] != exp_q[i]) ok = 1'b0;
    total++;
    if (!ok) begin
      bad++;
      $display("FAIL %s: grant order %p required %p", name, glog, exp_q);
    end
  endtask

  task automatic test_reset();
    do_reset();
    @(negedge aclk);
    total++;
    if ({gnt, src_id, adatain, asend, busy, err} !== '0) begin
      bad++;
      $display("FAIL reset_state: gnt=%b src=%0d dat=%h asend=%b busy=%b err=%b required all 0",
               gnt, src_id, adatain, asend, busy, err);
    end
  endtask

  task automatic test_single();
    logic ok;
    int exp_q[$];
    do_reset();
    load_words(1'b1);
    m_word[2] = 8'hA5;
    do_xfer(4'b0100, 3, 1'b0);
    exp_q = {2};
    check_order("single_order", exp_q);
    req = '0;
    ok = 1'b1;
    repeat (4) begin
      @(negedge aclk);
      if (asend !== 1'b0 || adatain !== 8'hA5 || src_id !== IW'(2)) ok = 1'b0;
    end
    total++;
    if (!ok) begin
      bad++;
      $display("FAIL single_idle: asend=%b dat=%h src=%0d required 0/a5/2", asend, adatain, src_id);
    end
  endtask

  task automatic test_pair();
    int exp_q[$];
    do_reset();
    load_words(1'b1);
    repeat (4) do_xfer(4'b0011, 3, 1'b0);
    exp_q = {0, 1, 0, 1};
    check_order("pair_order", exp_q);
  endtask

  task automatic test_rr_full();
    int exp_q[$];
    do_reset();
    repeat (5) do_xfer(4'b1111, 1, 1'b1);
    exp_q = {0, 1, 2, 3, 0};
    check_order("rr_full_order", exp_q);
  endtask

  task automatic test_ready_block();
    logic ok;
    int exp_q[$];
    do_reset();
    load_words(1'b1);
    aready = 1'b0;
    req    = 4'b0001;
    ok = 1'b1;
    repeat (5) begin
      @(negedge aclk);
      if (asend !== 1'b0 || gnt !== '0 || busy !== 1'b0) ok = 1'b0;
    end
    total++;
    if (!ok) begin
      bad++;
      $display("FAIL ready_block: asend=%b gnt=%b busy=%b required 0/0/0", asend, gnt, busy);
    end
    do_xfer(4'b0001, 1, 1'b0);
    exp_q = {0};
    check_order("ready_release_order", exp_q);
    aready = 1'b0;
    req    = 4'b0010;
    repeat (3) @(negedge aclk);
    req    = '0;
    aready = 1'b1;
    ok = 1'b1;
    repeat (5) begin
      @(negedge aclk);
      if (asend !== 1'b0 || gnt !== '0 || busy !== 1'b0 || err !== 1'b0) ok = 1'b0;
    end
    total++;
    if (!ok) begin
      bad++;
      $display("FAIL dropped_req: asend=%b gnt=%b busy=%b err=%b required 0/0/0/0", asend, gnt, busy, err);
    end
  endtask

  task automatic test_watchdog();
    int n;
    do_reset();
    load_words(1'b1);
    req    = 4'b0001;
    aready = 1'b1;
    n = 0;
    do begin @(negedge aclk); n++; end while (asend !== 1'b1 && n < 6);
    total++;
    if (asend !== 1'b1 || src_id !== IW'(0)) begin
      bad++;
      $display("FAIL wd_grant: asend=%b src=%0d required 1/0", asend, src_id);
    end
    req    = '0;
    aready = 1'b0;
    // Cycle 1 is HOLD; cycles 2..9 are the first 8 WAIT cycles.
    for (int c = 1; c <= 15; c++) begin
      @(negedge aclk);
      if (c == 9) begin
        total++;
        if (err !== 1'b0) begin
          bad++;
          $display("FAIL wd_early: err=%b required 0 after 7 wait cycles", err);
        end
      end
      if (c == 10) begin
        total++;
        if (err !== 1'b1) begin
          bad++;
          $display("FAIL wd_fire: err=%b required 1 after 8 wait cycles", err);
        end
      end
    end
    total++;
    if (err !== 1'b1 || busy !== 1'b1 || asend !== 1'b0) begin
      bad++;
      $display("FAIL wd_stuck: err=%b busy=%b asend=%b required 1/1/0", err, busy, asend);
    end
    aready = 1'b1;
    repeat (3) @(negedge aclk);
    total++;
    if (err !== 1'b1 || busy !== 1'b0) begin
      bad++;
      $display("FAIL wd_sticky: err=%b busy=%b required 1/0", err, busy);
    end
    do_reset();
    @(negedge aclk);
    total++;
    if (err !== 1'b0) begin
      bad++;
      $display("FAIL wd_clear: err=%b required 0 after reset", err);
    end
  endtask

  task automatic test_reset_mid();
    int n;
    int exp_q[$];
    do_reset();
    load_words(1'b1);
    req    = 4'b0100;
    aready = 1'b1;
    n = 0;
    do begin @(negedge aclk); n++; end while (asend !== 1'b1 && n < 6);
    req    = '0;
    aready = 1'b0;
    repeat (3) @(negedge aclk);
    #2 arst_n = 1'b0;
    #1;
    total++;
    if ({gnt, src_id, adatain, asend, busy, err} !== '0) begin
      bad++;
      $display("FAIL reset_async: gnt=%b src=%0d dat=%h asend=%b busy=%b err=%b required all 0",
               gnt, src_id, adatain, asend, busy, err);
    end
    @(negedge aclk);
    arst_n = 1'b1;
    m_ptr  = NREQ - 1;
    glog.delete();
    do_xfer(4'b1111, 1, 1'b1);
    exp_q = {0};
    check_order("reset_ptr_order", exp_q);
  endtask

  task automatic test_random();
    do_reset();
    for (int t = 0; t < 40; t++)
      do_xfer(NREQ'($urandom_range(1, (1 << NREQ) - 1)), $urandom_range(0, 6), 1'b1);
  endtask

  initial begin
    test_reset();
    test_single();
    test_pair();
    test_rr_full();
    test_ready_block();
    test_watchdog();
    test_reset_mid();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
